// File: rtl/fetch_load_ctrl.sv
// Write-side loader for the 128x48 fetch buffer: packs a 64-bit beat stream into
// port-B half-row writes (low half first) and tracks committed rows for the reader.
module fetch_load_ctrl #(
  parameter int DATA_W   = 64,
  parameter int ROWS_MAX = 48,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [5:0]        rows_i,
  input  logic              data_valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              data_ready_o,
  output logic              web_o,
  output logic              wsb_o,
  output logic [ADDR_W-1:0] addrb_o,
  output logic [DATA_W-1:0] datab_o,
  output logic              busy_o,
  output logic [5:0]        rows_wr_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [5:0]          target_q;
  logic [ADDR_W-1:0]   row_q;
  logic                half_q;
  logic [5:0]          rows_wr_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic                web_q;
  logic                wsb_q;
  logic [ADDR_W-1:0]   addrb_q;
  logic [DATA_W-1:0]   datab_q;

  logic                hs_s;
  logic                last_s;
  logic [5:0]          target_d;

  assign hs_s     = ready_q & data_valid_i;
  assign last_s   = hs_s & half_q & (row_q == ADDR_W'(target_q - 6'd1));
  assign target_d = (rows_i > 6'(ROWS_MAX)) ? 6'(ROWS_MAX) : rows_i;

  // Load FSM with all outputs registered; a committed high-half write bumps rows_wr one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= 6'd0;
      row_q     <= '0;
      half_q    <= 1'b0;
      rows_wr_q <= 6'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      web_q     <= 1'b0;
      wsb_q     <= 1'b0;
      addrb_q   <= '0;
      datab_q   <= '0;
    end else begin
      web_q  <= 1'b0;
      done_q <= 1'b0;
      if (web_q && wsb_q) begin
        rows_wr_q <= rows_wr_q + 6'd1;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            target_q  <= target_d;
            row_q     <= '0;
            half_q    <= 1'b0;
            rows_wr_q <= 6'd0;
            busy_q    <= 1'b1;
            if (target_d != 6'd0) begin
              state_q <= LOAD;
              ready_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (hs_s) begin
            web_q   <= 1'b1;
            wsb_q   <= half_q;
            addrb_q <= row_q;
            datab_q <= data_i;
            half_q  <= ~half_q;
            if (half_q) begin
              row_q <= row_q + ADDR_W'(1);
            end
            // The final high-half beat is presented together with done.
            if (last_s) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready_o = ready_q;
  assign web_o        = web_q;
  assign wsb_o        = wsb_q;
  assign addrb_o      = addrb_q;
  assign datab_o      = datab_q;
  assign busy_o       = busy_q;
  assign rows_wr_o    = rows_wr_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_fetch_load_ctrl.sv
// Directed bench for fetch_load_ctrl: reset, full-rate, throttled, clamp/zero,
// start-while-busy and back-to-back loads, checked with immediate assertions.
module tb_fetch_load_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [5:0]  rows_i;
  logic        data_valid_i;
  logic [63:0] data_i;
  logic        data_ready_o;
  logic        web_o;
  logic        wsb_o;
  logic [5:0]  addrb_o;
  logic [63:0] datab_o;
  logic        busy_o;
  logic [5:0]  rows_wr_o;
  logic        done_o;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_load_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .rows_i       (rows_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .data_ready_o (data_ready_o),
    .web_o        (web_o),
    .wsb_o        (wsb_o),
    .addrb_o      (addrb_o),
    .datab_o      (datab_o),
    .busy_o       (busy_o),
    .rows_wr_o    (rows_wr_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int k);
    return {32'hC0DE_0000 + 32'(k), ~32'(k)};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},  64'(data_ready_o), 64'd0);
    chk({tag, "_web"},    64'(web_o),        64'd0);
    chk({tag, "_wsb"},    64'(wsb_o),        64'd0);
    chk({tag, "_addrb"},  64'(addrb_o),      64'd0);
    chk({tag, "_datab"},  datab_o,           64'd0);
    chk({tag, "_busy"},   64'(busy_o),       64'd0);
    chk({tag, "_rows_wr"},64'(rows_wr_o),    64'd0);
    chk({tag, "_done"},   64'(done_o),       64'd0);
  endtask

  // Full load: start, stream beats (optionally throttled / with a stray start), check every cycle.
  task automatic run_load(input logic [5:0] req, input int exp_rows, input bit throttle, input bit poke);
    int  k   = 0;
    int  rw  = 0;
    int  cyc = 0;
    bit  v;
    start_i      = 1'b1;
    rows_i       = req;
    data_valid_i = 1'b0;
    step();
    start_i = 1'b0;
    chk("start_busy",    64'(busy_o),       64'd1);
    chk("start_ready",   64'(data_ready_o), 64'd1);
    chk("start_rows_wr", 64'(rows_wr_o),    64'd0);
    chk("start_web",     64'(web_o),        64'd0);
    while (k < 2 * exp_rows) begin
      v = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      data_valid_i = v;
      data_i       = pat(k);
      if (poke && k == 1) begin
        start_i = 1'b1;
        rows_i  = 6'd5;
      end
      chk("ld_ready", 64'(data_ready_o), 64'd1);
      step();
      start_i = 1'b0;
      cyc++;
      chk("ld_rows_wr", 64'(rows_wr_o), 64'(rw));
      if (v) begin
        chk("ld_web",   64'(web_o),   64'd1);
        chk("ld_wsb",   64'(wsb_o),   64'(k % 2));
        chk("ld_addrb", 64'(addrb_o), 64'(k / 2));
        chk("ld_datab", datab_o,      pat(k));
        chk("ld_done",  64'(done_o),  64'(k == 2 * exp_rows - 1));
        if (k % 2 == 1) rw++;
        k++;
      end else begin
        chk("idle_web",  64'(web_o),  64'd0);
        chk("idle_done", 64'(done_o), 64'd0);
      end
      if (cyc > 2000) begin
        chk("ld_cycle_budget", 64'(cyc), 64'd0);
        break;
      end
    end
    chk("end_ready", 64'(data_ready_o), 64'd0);
    data_valid_i = 1'b0;
    step();
    chk("post_busy",    64'(busy_o),       64'd0);
    chk("post_ready",   64'(data_ready_o), 64'd0);
    chk("post_done",    64'(done_o),       64'd0);
    chk("post_web",     64'(web_o),        64'd0);
    chk("post_rows_wr", 64'(rows_wr_o),    64'(exp_rows));
  endtask

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    rows_i       = 6'd0;
    data_valid_i = 1'b0;
    data_i       = 64'd0;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Reset mid-load after three beats abandons the load.
    start_i = 1'b1;
    rows_i  = 6'd4;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_valid_i = 1'b1;
      data_i       = pat(i);
      step();
      chk("mid_addrb", 64'(addrb_o), 64'(i / 2));
    end
    rst_n        = 1'b0;
    data_valid_i = 1'b0;
    step();
    chk_all_zero("midrst");
    rst_n = 1'b1;
    step();
    chk("midrst_no_done", 64'(done_o), 64'd0);
    run_load(6'd2, 2, 1'b0, 1'b0);

    // Full-rate 48 rows, then back-to-back throttled load starting at f+2.
    run_load(6'd48, 48, 1'b0, 1'b0);
    run_load(6'd3, 3, 1'b1, 1'b0);

    // Clamp 60 -> 48.
    run_load(6'd60, 48, 1'b0, 1'b0);

    // Zero-row load: done one cycle after start, no write.
    start_i = 1'b1;
    rows_i  = 6'd0;
    step();
    start_i = 1'b0;
    chk("zero_done",    64'(done_o),       64'd1);
    chk("zero_busy",    64'(busy_o),       64'd1);
    chk("zero_web",     64'(web_o),        64'd0);
    chk("zero_ready",   64'(data_ready_o), 64'd0);
    chk("zero_rows_wr", 64'(rows_wr_o),    64'd0);
    step();
    chk("zero_done2",   64'(done_o),       64'd0);
    chk("zero_busy2",   64'(busy_o),       64'd0);
    chk("zero_web2",    64'(web_o),        64'd0);

    // Stray start mid-load is ignored; a new start is accepted afterwards.
    run_load(6'd2, 2, 1'b0, 1'b1);
    step();
    chk("poke_no_done", 64'(done_o), 64'd0);
    chk("poke_no_busy", 64'(busy_o), 64'd0);
    run_load(6'd1, 1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
